// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and data memory: queues word stores and drains them when loads leave the port free.
// Latency: stores drain one per non-load cycle; loads return on data_o exactly one cycle later, forwarded or from memory.
// Backpressure: stall_o rises only for a store arriving at a full buffer; loads never stall and take priority on the port.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [29:0]   buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          fwd_hit;
    logic [31:0]   fwd_data;

    logic          full;
    logic          enq;
    logic          drain;
    logic          hit_c;
    logic [31:0]   hit_data_c;
    logic [PW-1:0] idx;

    assign full  = (count == CW'(DEPTH));
    assign enq   = MemWrite_i && !full;
    // Loads own the port, so draining only happens in cycles without a load.
    assign drain = !MemRead_i && (count != '0);

    // Scan entries oldest to youngest so the last match is the youngest store.
    always_comb begin
        hit_c      = 1'b0;
        hit_data_c = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (buf_addr[idx] == addr_i[31:2])) begin
                hit_c      = 1'b1;
                hit_data_c = buf_data[idx];
            end
        end
    end

    // Entry payload storage; contents only matter while counted as valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            buf_addr[tail] <= addr_i[31:2];
            buf_data[tail] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards all pending stores.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (drain) begin
                head <= head + PW'(1);
            end
            case ({enq, drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Capture the forwarding decision with the load so data_o lines up with registered memory data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_hit  <= MemRead_i && hit_c;
            if (MemRead_i) begin
                fwd_data <= hit_data_c;
            end
        end
    end

    // Memory port mux: load first, otherwise drain the head entry; quiet during reset.
    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        if (rst_i) begin
            if (MemRead_i) begin
                mem_read_o = 1'b1;
                mem_addr_o = addr_i;
            end else if (count != '0) begin
                mem_write_o = 1'b1;
                mem_addr_o  = {buf_addr[head], 2'b00};
                mem_data_o  = buf_data[head];
            end
        end
    end

    assign stall_o = MemWrite_i && full;
    assign empty_o = (count == '0);
    assign data_o  = fwd_hit ? fwd_data : mem_data_i;

endmodule
